// File: rtl/reservation_station.sv
// Reservation station: holds issued instructions until both operands are
// available, presents the lowest-index ready entry to the ALU, and frees
// an entry once its own result has been broadcast on the CDB.
module reservation_station #(
  parameter int          DEPTH      = 3,
  parameter logic [3:0]  BASE_LABEL = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [5:0]  selALU,
  input  logic [3:0]  label1,
  input  logic [3:0]  label2,
  input  logic [31:0] value1,
  input  logic [31:0] value2,
  output logic        full,
  output logic [3:0]  issue_label,
  input  logic        cdb_valid,
  input  logic [3:0]  cdb_label,
  input  logic [31:0] cdb_data,
  output logic        disp_valid,
  input  logic        disp_ready,
  output logic [5:0]  disp_op,
  output logic [31:0] disp_a,
  output logic [31:0] disp_b,
  output logic [3:0]  disp_label
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] exec;
  logic [5:0]       op [DEPTH];
  logic [3:0]       q1 [DEPTH];
  logic [3:0]       q2 [DEPTH];
  logic [31:0]      v1 [DEPTH];
  logic [31:0]      v2 [DEPTH];

  logic          free_found;
  logic [IW-1:0] free_idx;
  logic          disp_found;
  logic [IW-1:0] disp_idx;
  logic          cdb_hit;
  logic          accept;

  // A zero label never names a producer, so it must never match anything.
  assign cdb_hit = cdb_valid && (cdb_label != 4'd0);
  assign accept  = issue_valid && !full;

  // Lowest free entry and lowest dispatchable entry, both from registered state.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (busy[i] && !exec[i] && q1[i] == 4'd0 && q2[i] == 4'd0) begin
        disp_found = 1'b1;
        disp_idx   = IW'(i);
      end
    end
  end

  assign full        = &busy;
  assign issue_label = free_found ? 4'(BASE_LABEL + 4'(free_idx)) : 4'd0;

  // Dispatch port is forced to zero whenever nothing is presented.
  always_comb begin
    disp_valid = disp_found;
    disp_op    = '0;
    disp_a     = '0;
    disp_b     = '0;
    disp_label = '0;
    if (disp_found) begin
      disp_op    = op[disp_idx];
      disp_a     = v1[disp_idx];
      disp_b     = v2[disp_idx];
      disp_label = 4'(BASE_LABEL + 4'(disp_idx));
    end
  end

  // Per-entry update: release, operand snoop, dispatch mark and accept.
  // Accept only targets a non-busy entry while the others only touch busy
  // ones, so all four can happen in one cycle without interfering.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        busy[i] <= 1'b0;
        exec[i] <= 1'b0;
        op[i]   <= '0;
        q1[i]   <= '0;
        q2[i]   <= '0;
        v1[i]   <= '0;
        v2[i]   <= '0;
      end else if (busy[i]) begin
        if (cdb_hit && q1[i] == cdb_label) begin
          v1[i] <= cdb_data;
          q1[i] <= 4'd0;
        end
        if (cdb_hit && q2[i] == cdb_label) begin
          v2[i] <= cdb_data;
          q2[i] <= 4'd0;
        end
        if (disp_found && disp_ready && int'(disp_idx) == i)
          exec[i] <= 1'b1;
        if (exec[i] && cdb_hit && cdb_label == 4'(BASE_LABEL + 4'(i))) begin
          busy[i] <= 1'b0;
          exec[i] <= 1'b0;
        end
      end else if (accept && int'(free_idx) == i) begin
        busy[i] <= 1'b1;
        exec[i] <= 1'b0;
        op[i]   <= selALU;
        if (label1 == 4'd0) begin
          v1[i] <= value1;
          q1[i] <= 4'd0;
        end else if (cdb_hit && cdb_label == label1) begin
          v1[i] <= cdb_data;
          q1[i] <= 4'd0;
        end else begin
          v1[i] <= '0;
          q1[i] <= label1;
        end
        if (label2 == 4'd0) begin
          v2[i] <= value2;
          q2[i] <= 4'd0;
        end else if (cdb_hit && cdb_label == label2) begin
          v2[i] <= cdb_data;
          q2[i] <= 4'd0;
        end else begin
          v2[i] <= '0;
          q2[i] <= label2;
        end
      end
    end
  end

endmodule
